// File: rtl/alu_decode_stage_if.sv
// Handshake bundle for alu_decode_stage: the upstream side offers an instruction
// with its PC and register operands, and the downstream side takes the decoded
// ALU bundle. out_mode carries the packed {operation, signedness} ALU mode.
interface alu_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_mode;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_br_invert;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_mode, out_a, out_b, out_rd, out_br_invert, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_mode, out_a, out_b, out_rd, out_br_invert, out_illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage in front of the ALU. It decodes one instruction into
// an ALU mode plus two operands and holds the result in a one-entry register.
// The stage uses valid/ready handshakes on both sides and sustains one
// instruction per cycle. Undecodable words are passed on as ALU_NULL with the
// illegal flag set, so that the exception is raised downstream.
package Types;
    typedef enum logic [3:0] {
        ALU_NULL          = 4'd0,
        ALU_ADD           = 4'd1,
        ALU_SUB           = 4'd2,
        ALU_SHIFT_LEFT    = 4'd3,
        ALU_SHIFT_RIGHT   = 4'd4,
        ALU_SET_LESS_THAN = 4'd5,
        ALU_XOR           = 4'd6,
        ALU_OR            = 4'd7,
        ALU_AND           = 4'd8,
        ALU_EQ            = 4'd9
    } alu_op_t;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } alu_sign_t;

    typedef struct packed {
        alu_op_t   op;
        alu_sign_t sign;
    } alu_mode_t;
endpackage

module alu_decode_stage
    import Types::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_BRANCH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    alu_decode_stage_if.slave bus
);

    if (XLEN != 32) begin : g_xlen_check
        $fatal(1, "alu_decode_stage: only XLEN=32 is supported");
    end

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // funct3 map that OP and OP-IMM share. Left shift and logical right shift
    // are always unsigned, because the ALU faults on a signed left shift.
    function automatic alu_mode_t base_mode(input logic [2:0] funct3);
        alu_mode_t m;
        case (funct3)
            3'b000:  m = '{op: ALU_ADD,           sign: UNSIGNED};
            3'b001:  m = '{op: ALU_SHIFT_LEFT,    sign: UNSIGNED};
            3'b010:  m = '{op: ALU_SET_LESS_THAN, sign: SIGNED};
            3'b011:  m = '{op: ALU_SET_LESS_THAN, sign: UNSIGNED};
            3'b100:  m = '{op: ALU_XOR,           sign: UNSIGNED};
            3'b101:  m = '{op: ALU_SHIFT_RIGHT,   sign: UNSIGNED};
            3'b110:  m = '{op: ALU_OR,            sign: UNSIGNED};
            3'b111:  m = '{op: ALU_AND,           sign: UNSIGNED};
            default: m = '{op: ALU_NULL,          sign: UNSIGNED};
        endcase
        return m;
    endfunction

    logic [31:0] instr_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_field_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_u_s;
    logic [31:0] shamt_s;

    assign instr_s    = bus.in_instr;
    assign opcode_s   = instr_s[6:0];
    assign funct3_s   = instr_s[14:12];
    assign funct7_s   = instr_s[31:25];
    assign rd_field_s = instr_s[11:7];
    assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_s_s    = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_u_s    = {instr_s[31:12], 12'h000};
    assign shamt_s    = {27'd0, instr_s[24:20]};

    alu_mode_t   raw_mode_s;
    logic [31:0] raw_a_s;
    logic [31:0] raw_b_s;
    logic [4:0]  raw_rd_s;
    logic        raw_inv_s;
    logic        raw_ill_s;

    // Decode by opcode class. Fields are provisional until the illegal squash.
    always_comb begin
        raw_mode_s = '{op: ALU_NULL, sign: UNSIGNED};
        raw_a_s    = 32'd0;
        raw_b_s    = 32'd0;
        raw_rd_s   = 5'd0;
        raw_inv_s  = 1'b0;
        raw_ill_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                raw_a_s  = bus.in_rs1;
                raw_b_s  = bus.in_rs2;
                raw_rd_s = rd_field_s;
                if (funct7_s == F7_BASE) begin
                    raw_mode_s = base_mode(funct3_s);
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
                    raw_mode_s = '{op: ALU_SUB, sign: UNSIGNED};
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
                    raw_mode_s = '{op: ALU_SHIFT_RIGHT, sign: SIGNED};
                end else begin
                    raw_ill_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                raw_a_s  = bus.in_rs1;
                raw_rd_s = rd_field_s;
                case (funct3_s)
                    3'b001: begin
                        raw_b_s = shamt_s;
                        if (funct7_s == F7_BASE) begin
                            raw_mode_s = '{op: ALU_SHIFT_LEFT, sign: UNSIGNED};
                        end else begin
                            raw_ill_s = 1'b1;
                        end
                    end
                    3'b101: begin
                        raw_b_s = shamt_s;
                        if (funct7_s == F7_BASE) begin
                            raw_mode_s = '{op: ALU_SHIFT_RIGHT, sign: UNSIGNED};
                        end else if (funct7_s == F7_ALT) begin
                            raw_mode_s = '{op: ALU_SHIFT_RIGHT, sign: SIGNED};
                        end else begin
                            raw_ill_s = 1'b1;
                        end
                    end
                    default: begin
                        raw_b_s    = imm_i_s;
                        raw_mode_s = base_mode(funct3_s);
                    end
                endcase
            end
            OPC_LUI: begin
                raw_b_s    = imm_u_s;
                raw_rd_s   = rd_field_s;
                raw_mode_s = '{op: ALU_ADD, sign: UNSIGNED};
            end
            OPC_AUIPC: begin
                raw_a_s    = bus.in_pc;
                raw_b_s    = imm_u_s;
                raw_rd_s   = rd_field_s;
                raw_mode_s = '{op: ALU_ADD, sign: UNSIGNED};
            end
            OPC_JAL, OPC_JALR: begin
                raw_a_s    = bus.in_pc;
                raw_b_s    = 32'd4;
                raw_rd_s   = rd_field_s;
                raw_mode_s = '{op: ALU_ADD, sign: UNSIGNED};
            end
            OPC_LOAD: begin
                raw_a_s    = bus.in_rs1;
                raw_b_s    = imm_i_s;
                raw_rd_s   = rd_field_s;
                raw_mode_s = '{op: ALU_ADD, sign: UNSIGNED};
            end
            OPC_STORE: begin
                raw_a_s    = bus.in_rs1;
                raw_b_s    = imm_s_s;
                raw_mode_s = '{op: ALU_ADD, sign: UNSIGNED};
            end
            OPC_BRANCH: begin
                raw_a_s = bus.in_rs1;
                raw_b_s = bus.in_rs2;
                if (EN_BRANCH) begin
                    case (funct3_s)
                        3'b000: raw_mode_s = '{op: ALU_EQ, sign: UNSIGNED};
                        3'b001: begin
                            raw_mode_s = '{op: ALU_EQ, sign: UNSIGNED};
                            raw_inv_s  = 1'b1;
                        end
                        3'b100: raw_mode_s = '{op: ALU_SET_LESS_THAN, sign: SIGNED};
                        3'b101: begin
                            raw_mode_s = '{op: ALU_SET_LESS_THAN, sign: SIGNED};
                            raw_inv_s  = 1'b1;
                        end
                        3'b110: raw_mode_s = '{op: ALU_SET_LESS_THAN, sign: UNSIGNED};
                        3'b111: begin
                            raw_mode_s = '{op: ALU_SET_LESS_THAN, sign: UNSIGNED};
                            raw_inv_s  = 1'b1;
                        end
                        default: raw_ill_s = 1'b1;
                    endcase
                end else begin
                    raw_ill_s = 1'b1;
                end
            end
            default: raw_ill_s = 1'b1;
        endcase
    end

    alu_mode_t   dec_mode_s;
    logic [31:0] dec_a_s;
    logic [31:0] dec_b_s;
    logic [4:0]  dec_rd_s;
    logic        dec_inv_s;
    logic        dec_ill_s;

    // Illegal words reach the ALU as a harmless NULL op with zero operands.
    always_comb begin
        dec_mode_s = '{op: ALU_NULL, sign: UNSIGNED};
        dec_a_s    = 32'd0;
        dec_b_s    = 32'd0;
        dec_rd_s   = 5'd0;
        dec_inv_s  = 1'b0;
        dec_ill_s  = 1'b0;
        if (raw_ill_s) begin
            dec_ill_s = 1'b1;
        end else begin
            dec_mode_s = raw_mode_s;
            dec_a_s    = raw_a_s;
            dec_b_s    = raw_b_s;
            dec_rd_s   = raw_rd_s;
            dec_inv_s  = raw_inv_s;
        end
    end

    logic        valid_r;
    alu_mode_t   mode_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [4:0]  rd_r;
    logic        inv_r;
    logic        ill_r;
    logic        in_ready_s;
    logic        load_s;

    assign in_ready_s = ~valid_r | bus.out_ready;
    assign load_s     = bus.in_valid & in_ready_s;

    // One-entry pipeline register. Reset beats flush, and flush beats a load
    // in the same cycle. The entry stays frozen while it is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            mode_r  <= '{op: ALU_NULL, sign: UNSIGNED};
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            rd_r    <= 5'd0;
            inv_r   <= 1'b0;
            ill_r   <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r <= 1'b1;
            mode_r  <= dec_mode_s;
            a_r     <= dec_a_s;
            b_r     <= dec_b_s;
            rd_r    <= dec_rd_s;
            inv_r   <= dec_inv_s;
            ill_r   <= dec_ill_s;
        end else if (bus.out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = valid_r;
    assign bus.out_mode      = mode_r;
    assign bus.out_a         = a_r;
    assign bus.out_b         = b_r;
    assign bus.out_rd        = rd_r;
    assign bus.out_br_invert = inv_r;
    assign bus.out_illegal   = ill_r;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage. It runs directed decode vectors,
// checks handshake corner cases and runs a randomized run that is compared with
// a table-driven reference decoder and a one-entry occupancy model.
module tb_alu_decode_stage;

    localparam logic [3:0] OP_NULL = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_EQ   = 4'd9;

    // Operation and signedness by funct3 for the register/immediate ALU groups.
    localparam logic [31:0] F3_OP  = {OP_AND, OP_OR, OP_SRL, OP_XOR, OP_SLT, OP_SLT, OP_SLL, OP_ADD};
    localparam logic [7:0]  F3_SGN = 8'b0000_0100;

    typedef struct packed {
        logic [4:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        inv;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    alu_decode_stage_if bus();

    alu_decode_stage #(.XLEN(32), .EN_BRANCH(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic [4:0] mode, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] rd, input logic inv, input logic ill);
        exp_t e;
        e.mode = mode; e.a = a; e.b = b; e.rd = rd; e.inv = inv; e.ill = ill;
        return e;
    endfunction

    // Reference decoder: instruction-format rules applied directly to the word.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic        legal;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        f3    = w[14:12];
        f7    = w[31:25];
        imm_i = 32'($signed(w[31:20]));
        imm_s = 32'($signed({w[31:25], w[11:7]}));
        imm_u = w & 32'hFFFF_F000;
        legal = 1'b1;
        e     = '0;
        case (w[6:0])
            7'h33: begin
                e.a = r1; e.b = r2; e.rd = w[11:7];
                if (f7 == 7'h00) e.mode = {F3_OP[int'(f3)*4 +: 4], F3_SGN[f3]};
                else if (f7 == 7'h20 && f3 == 3'd0) e.mode = {OP_SUB, 1'b0};
                else if (f7 == 7'h20 && f3 == 3'd5) e.mode = {OP_SRL, 1'b1};
                else legal = 1'b0;
            end
            7'h13: begin
                e.a = r1; e.rd = w[11:7];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = {27'd0, w[24:20]};
                    if (f7 == 7'h00) e.mode = {F3_OP[int'(f3)*4 +: 4], 1'b0};
                    else if (f7 == 7'h20 && f3 == 3'd5) e.mode = {OP_SRL, 1'b1};
                    else legal = 1'b0;
                end else begin
                    e.b = imm_i;
                    e.mode = {F3_OP[int'(f3)*4 +: 4], F3_SGN[f3]};
                end
            end
            7'h37: begin e.a = 32'd0; e.b = imm_u; e.rd = w[11:7]; e.mode = {OP_ADD, 1'b0}; end
            7'h17: begin e.a = pc; e.b = imm_u; e.rd = w[11:7]; e.mode = {OP_ADD, 1'b0}; end
            7'h6F, 7'h67: begin e.a = pc; e.b = 32'd4; e.rd = w[11:7]; e.mode = {OP_ADD, 1'b0}; end
            7'h03: begin e.a = r1; e.b = imm_i; e.rd = w[11:7]; e.mode = {OP_ADD, 1'b0}; end
            7'h23: begin e.a = r1; e.b = imm_s; e.rd = 5'd0; e.mode = {OP_ADD, 1'b0}; end
            7'h63: begin
                e.a = r1; e.b = r2; e.rd = 5'd0;
                if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
                else if (f3 < 3'd2) e.mode = {OP_EQ, 1'b0};
                else e.mode = {OP_SLT, ~f3[1]};
                e.inv = f3[0];
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned k;
        int unsigned j;
        w = $urandom;
        k = $urandom_range(0, 11);
        j = $urandom_range(0, 3);
        case (k)
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            4:       w[6:0] = 7'h37;
            5:       w[6:0] = 7'h17;
            6:       w[6:0] = 7'h6F;
            7:       w[6:0] = 7'h67;
            8:       w[6:0] = 7'h03;
            9:       w[6:0] = 7'h23;
            10:      w[6:0] = 7'h63;
            default: w[6:0] = w[6:0];
        endcase
        if (k <= 3 && j <= 1) w[31:25] = 7'h00;
        else if (k <= 3 && j == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_mode !== 5'd0) begin errors++; $display("FAIL reset_mode: got %h want 00", bus.out_mode); end
        checks++; if (bus.out_a !== 32'd0) begin errors++; $display("FAIL reset_a: got %h want 0", bus.out_a); end
        checks++; if (bus.out_b !== 32'd0) begin errors++; $display("FAIL reset_b: got %h want 0", bus.out_b); end
        checks++; if (bus.out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h want 0", bus.out_rd); end
        checks++; if ({bus.out_br_invert, bus.out_illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus.out_br_invert, bus.out_illegal}); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{32'h002081B3, 32'h0, 32'd5, 32'd7, mk_exp({OP_ADD, 1'b0}, 32'd5, 32'd7, 5'd3, 1'b0, 1'b0)});
        v.push_back('{32'h402081B3, 32'h0, 32'd1, 32'd2, mk_exp({OP_SUB, 1'b0}, 32'd1, 32'd2, 5'd3, 1'b0, 1'b0)});
        v.push_back('{32'h41F35293, 32'h0, 32'h8000_0000, 32'd0, mk_exp({OP_SRL, 1'b1}, 32'h8000_0000, 32'd31, 5'd5, 1'b0, 1'b0)});
        v.push_back('{32'h00331293, 32'h0, 32'd9, 32'd0, mk_exp({OP_SLL, 1'b0}, 32'd9, 32'd3, 5'd5, 1'b0, 1'b0)});
        v.push_back('{32'h0020F063, 32'h0, 32'd1, 32'd2, mk_exp({OP_SLT, 1'b0}, 32'd1, 32'd2, 5'd0, 1'b1, 1'b0)});
        v.push_back('{32'hABCDE0B7, 32'h0, 32'h1234, 32'h5678, mk_exp({OP_ADD, 1'b0}, 32'd0, 32'hABCD_E000, 5'd1, 1'b0, 1'b0)});
        v.push_back('{32'hFFFFFFFF, 32'h40, 32'h11, 32'h22, mk_exp({OP_NULL, 1'b0}, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1)});
        v.push_back('{32'h022081B3, 32'h0, 32'h11, 32'h22, mk_exp({OP_NULL, 1'b0}, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1)});
        v.push_back('{32'h00209063, 32'h0, 32'd1, 32'd2, mk_exp({OP_EQ, 1'b0}, 32'd1, 32'd2, 5'd0, 1'b1, 1'b0)});
        v.push_back('{32'hFFF00093, 32'h0, 32'h10, 32'd0, mk_exp({OP_ADD, 1'b0}, 32'h10, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b0)});
        v.push_back('{32'h000000EF, 32'h100, 32'h7, 32'h8, mk_exp({OP_ADD, 1'b0}, 32'h100, 32'd4, 5'd1, 1'b0, 1'b0)});
        v.push_back('{32'hFE20AE23, 32'h0, 32'h1000, 32'h55, mk_exp({OP_ADD, 1'b0}, 32'h1000, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0)});
        v.push_back('{32'h0020C063, 32'h0, 32'd3, 32'd4, mk_exp({OP_SLT, 1'b1}, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0)});
        v.push_back('{32'h0020A063, 32'h0, 32'd3, 32'd4, mk_exp({OP_NULL, 1'b0}, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1)});
        v.push_back('{32'h00001117, 32'h200, 32'd0, 32'd0, mk_exp({OP_ADD, 1'b0}, 32'h200, 32'h1000, 5'd2, 1'b0, 1'b0)});
        v.push_back('{32'h403150B3, 32'h0, 32'hF000_0000, 32'd4, mk_exp({OP_SRL, 1'b1}, 32'hF000_0000, 32'd4, 5'd1, 1'b0, 1'b0)});
        v.push_back('{32'h40331293, 32'h0, 32'd9, 32'd0, mk_exp({OP_NULL, 1'b0}, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1)});
        v.push_back('{32'h002081B2, 32'h0, 32'd5, 32'd7, mk_exp({OP_NULL, 1'b0}, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1)});
        bus.out_ready = 1'b1;
        foreach (v[i]) begin
            bus.in_valid = 1'b1;
            bus.in_instr = v[i].instr;
            bus.in_pc    = v[i].pc;
            bus.in_rs1   = v[i].rs1;
            bus.in_rs2   = v[i].rs2;
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_mode !== v[i].e.mode) begin errors++; $display("FAIL dir%0d_mode: got %h want %h", i, bus.out_mode, v[i].e.mode); end
            checks++; if (bus.out_a !== v[i].e.a) begin errors++; $display("FAIL dir%0d_a: got %h want %h", i, bus.out_a, v[i].e.a); end
            checks++; if (bus.out_b !== v[i].e.b) begin errors++; $display("FAIL dir%0d_b: got %h want %h", i, bus.out_b, v[i].e.b); end
            checks++; if (bus.out_rd !== v[i].e.rd) begin errors++; $display("FAIL dir%0d_rd: got %h want %h", i, bus.out_rd, v[i].e.rd); end
            checks++; if ({bus.out_br_invert, bus.out_illegal} !== {v[i].e.inv, v[i].e.ill}) begin
                errors++; $display("FAIL dir%0d_flags: got %b want %b", i, {bus.out_br_invert, bus.out_illegal}, {v[i].e.inv, v[i].e.ill});
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_instr = 32'h002081B3; bus.in_pc = 32'h0; bus.in_rs1 = 32'h11; bus.in_rs2 = 32'h22;
        @(posedge clk);
        #1;
        bus.in_instr = 32'h402081B3; bus.in_rs1 = 32'd3; bus.in_rs2 = 32'd4;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_in_ready: got %b want 0", c, bus.in_ready); end
            checks++; if ({bus.out_valid, bus.out_mode, bus.out_a, bus.out_b} !== {1'b1, OP_ADD, 1'b0, 32'h11, 32'h22}) begin
                errors++; $display("FAIL stall%0d_hold: got %b/%h/%h/%h want 1/02/11/22", c, bus.out_valid, bus.out_mode, bus.out_a, bus.out_b);
            end
            @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_mode, bus.out_a, bus.out_b} !== {1'b1, OP_SUB, 1'b0, 32'd3, 32'd4}) begin
            errors++; $display("FAIL stall_next: got %b/%h/%h/%h want 1/04/3/4", bus.out_valid, bus.out_mode, bus.out_a, bus.out_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        // Empty stage: flush together with an offered instruction drops it.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; flush = 1'b1;
        bus.in_instr = 32'h002081B3; bus.in_rs1 = 32'd1; bus.in_rs2 = 32'd2;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_load: got %b want 0", bus.out_valid); end
        // Held entry flushed while stalled.
        flush = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup: got %b want 1", bus.out_valid); end
        flush = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: got %b want 0", bus.out_valid); end
        // Consuming entry plus new load plus flush: nothing remains.
        flush = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1; flush = 1'b1; bus.in_instr = 32'h402081B3;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_consume_load: got %b want 0", bus.out_valid); end
        flush = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.in_instr = 32'h0020F063; bus.in_rs1 = 32'h77; bus.in_rs2 = 32'h88;
        @(posedge clk);
        #1;
        checks++; if ({bus.out_valid, bus.out_br_invert} !== 2'b11) begin errors++; $display("FAIL rst_setup: got %b want 11", {bus.out_valid, bus.out_br_invert}); end
        reset = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({bus.out_valid, bus.out_mode, bus.out_a, bus.out_b, bus.out_rd, bus.out_br_invert, bus.out_illegal} !== '0) begin
            errors++; $display("FAIL rst_mid_stall: got %b/%h/%h/%h/%h/%b/%b want all 0", bus.out_valid, bus.out_mode, bus.out_a, bus.out_b, bus.out_rd, bus.out_br_invert, bus.out_illegal);
        end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        reset = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic exp_valid;
        logic exp_ready;
        exp_t exp_e;
        exp_t cand;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_e = '0;
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            bus.in_instr  = rand_instr();
            bus.in_pc     = $urandom & 32'hFFFF_FFFC;
            bus.in_rs1    = $urandom;
            bus.in_rs2    = $urandom;
            #1;
            exp_ready = !exp_valid || bus.out_ready;
            checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rand%0d_in_ready: got %b want %b", i, bus.in_ready, exp_ready); end
            cand = ref_decode(bus.in_instr, bus.in_pc, bus.in_rs1, bus.in_rs2);
            @(posedge clk);
            #1;
            if (flush) exp_valid = 1'b0;
            else if (bus.in_valid && exp_ready) begin exp_valid = 1'b1; exp_e = cand; end
            else if (bus.out_ready) exp_valid = 1'b0;
            checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL rand%0d_valid: got %b want %b", i, bus.out_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if ({bus.out_mode, bus.out_a, bus.out_b, bus.out_rd, bus.out_br_invert, bus.out_illegal} !== exp_e) begin
                    errors++;
                    $display("FAIL rand%0d_entry: got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b", i,
                             bus.out_mode, bus.out_a, bus.out_b, bus.out_rd, bus.out_br_invert, bus.out_illegal,
                             exp_e.mode, exp_e.a, exp_e.b, exp_e.rd, exp_e.inv, exp_e.ill);
                end
            end
        end
        bus.in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0;
        bus.in_rs1 = 32'd0; bus.in_rs2 = 32'd0; bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
